// File: rtl/lc3_dmem_responder.sv
// lc3_dmem_responder: slave end of the LC3 dmem request/complete interface.
// Services single-word reads and writes after a programmable number of wait
// cycles, pulses complete_data when each access finishes, and counts
// completed reads and writes with saturation.
//
// Handshake: the initiator raises dmem_req and holds it until it sees
// complete_data; the responder samples we/addr/wdata/wait selection only on
// the accept edge (IDLE with dmem_req=1). complete_data is a single-cycle
// pulse. Dropping dmem_req early never aborts an accepted access.
module lc3_dmem_responder #(
    parameter int          ADDR_BITS    = 8,
    parameter logic [3:0]  DEFAULT_WAIT = 4'd2,
    parameter logic [15:0] ERR_RDATA    = 16'hDEAD
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [15:0] dmem_addr,
    input  logic [15:0] dmem_wdata,
    input  logic        wait_override_en,
    input  logic [3:0]  wait_override,
    output logic [15:0] dmem_rdata,
    output logic        complete_data,
    output logic        busy,
    output logic        addr_err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [1:0]  state_dbg
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [3:0]  load_wait;
    logic        out_of_range;
    logic [ADDR_BITS-1:0] idx;

    logic [15:0] mem [DEPTH];

    // Wait count chosen at accept time.
    assign load_wait    = wait_override_en ? wait_override : DEFAULT_WAIT;
    // Any address bit above the implemented range makes the access illegal.
    assign out_of_range = (lat_addr >> ADDR_BITS) != 16'd0;
    assign idx          = lat_addr[ADDR_BITS-1:0];
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

    // Control FSM, latched request, registered response and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            wcnt          <= 4'd0;
            lat_we        <= 1'b0;
            lat_addr      <= 16'd0;
            lat_wdata     <= 16'd0;
            dmem_rdata    <= 16'd0;
            complete_data <= 1'b0;
            addr_err      <= 1'b0;
            rd_count      <= 16'd0;
            wr_count      <= 16'd0;
        end else begin
            complete_data <= 1'b0;
            addr_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (dmem_req) begin
                        lat_we    <= dmem_we;
                        lat_addr  <= dmem_addr;
                        lat_wdata <= dmem_wdata;
                        wcnt      <= load_wait;
                        state     <= (load_wait != 4'd0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wcnt <= 4'd1) begin
                        wcnt  <= 4'd0;
                        state <= S_ACCESS;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    // Result is registered here so it is visible in DONE.
                    state         <= S_DONE;
                    complete_data <= 1'b1;
                    addr_err      <= out_of_range;
                    if (lat_we) begin
                        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                    end else begin
                        dmem_rdata <= out_of_range ? ERR_RDATA : mem[idx];
                        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array; not reset. An out-of-range write leaves it untouched.
    always_ff @(posedge clock) begin
        if (state == S_ACCESS && lat_we && !out_of_range) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Testbench for lc3_dmem_responder: directed scenarios plus randomized
// accesses, checked by a scoreboard fed from the driver and drained by an
// independent monitor on every completion.
module tb_lc3_dmem_responder;

    localparam int          DEF_WAIT = 2;
    localparam logic [15:0] ERR_VAL  = 16'hDEAD;

    logic        clock;
    logic        reset_n;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        wait_override_en;
    logic [3:0]  wait_override;
    logic [15:0] dmem_rdata;
    logic        complete_data;
    logic        busy;
    logic        addr_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [1:0]  state_dbg;

    lc3_dmem_responder dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .wait_override_en (wait_override_en),
        .wait_override    (wait_override),
        .dmem_rdata       (dmem_rdata),
        .complete_data    (complete_data),
        .busy             (busy),
        .addr_err         (addr_err),
        .rd_count         (rd_count),
        .wr_count         (wr_count),
        .state_dbg        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    // Entry: {is_read, addr_err, rdata[15:0], rd_count[15:0], wr_count[15:0]}
    logic [49:0] exp_q[$];
    logic [15:0] ref_mem [int];
    int          written_q[$];
    int          m_rd;
    int          m_wr;
    int          n_checks;
    int          n_fail;
    int          idle_completes;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            if (complete_data) begin
                idle_completes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_complete", 32'd1, 32'd0);
                end else begin
                    logic [49:0] e;
                    e = exp_q.pop_front();
                    if (e[49]) chk("rdata", {16'd0, dmem_rdata}, {16'd0, e[47:32]});
                    chk("addr_err", {31'd0, addr_err}, {31'd0, e[48]});
                    chk("rd_count", {16'd0, rd_count}, {16'd0, e[31:16]});
                    chk("wr_count", {16'd0, wr_count}, {16'd0, e[15:0]});
                end
            end else if (addr_err) begin
                chk("addr_err_without_complete", 32'd1, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic oen, input logic [3:0] ov, input bit disturb);
        int  w;
        bit  oor;
        logic [15:0] rdata;
        int  lat;
        int  busy_n;
        bit  done;
        w     = oen ? int'(ov) : DEF_WAIT;
        oor   = (addr[15:8] != 8'd0);
        rdata = 16'd0;
        if (we) begin
            m_wr++;
            if (!oor) begin
                ref_mem[int'(addr)] = wdata;
                written_q.push_back(int'(addr));
            end
        end else begin
            m_rd++;
            rdata = oor ? ERR_VAL : ref_mem[int'(addr)];
        end
        exp_q.push_back({!we, oor, rdata, sat16(m_rd), sat16(m_wr)});

        @(negedge clock);
        dmem_req         = 1'b1;
        dmem_we          = we;
        dmem_addr        = addr;
        dmem_wdata       = wdata;
        wait_override_en = oen;
        wait_override    = ov;
        @(posedge clock);
        lat    = 0;
        busy_n = 0;
        done   = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
            if (busy) busy_n++;
            if (complete_data) done = 1;
            if (disturb && lat == 1) begin
                dmem_we       = ~we;
                dmem_addr     = 16'($urandom_range(0, 65535));
                dmem_wdata    = 16'($urandom_range(0, 65535));
                wait_override = 4'($urandom_range(0, 15));
                dmem_req      = 1'b0;
            end
        end
        chk("latency", lat, w + 2);
        chk("busy_cycles", busy_n, w + 2);
        dmem_req = 1'b0;
    endtask

    // Reset asserted while the access is still in WAIT: it must vanish.
    task automatic reset_mid_access();
        @(negedge clock);
        dmem_req         = 1'b1;
        dmem_we          = 1'b1;
        dmem_addr        = 16'h0005;
        dmem_wdata       = 16'h5555;
        wait_override_en = 1'b1;
        wait_override    = 4'd4;
        @(posedge clock);
        @(negedge clock);
        @(negedge clock);
        reset_n  = 1'b0;
        dmem_req = 1'b0;
        m_rd = 0;
        m_wr = 0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_complete", {31'd0, complete_data}, 32'd0);
        chk("rst_mid_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst_mid_wr_count", {16'd0, wr_count}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        m_rd = 0;
        m_wr = 0;
        idle_completes = 0;
        reset_n = 1'b0;
        dmem_req = 1'b0;
        dmem_we = 1'b0;
        dmem_addr = 16'd0;
        dmem_wdata = 16'd0;
        wait_override_en = 1'b0;
        wait_override = 4'd0;

        // Reset then idle.
        repeat (3) @(negedge clock);
        chk("rst_rdata", {16'd0, dmem_rdata}, 32'd0);
        chk("rst_complete", {31'd0, complete_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (busy) chk("idle_busy", 32'd1, 32'd0);
        end
        chk("idle_no_complete", idle_completes, 0);

        // Write then read, no wait cycles.
        do_access(1'b1, 16'h0005, 16'h1234, 1'b1, 4'd0, 0);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, 4'd0, 0);
        // Default wait and maximal override.
        do_access(1'b0, 16'h0005, 16'h0000, 1'b0, 4'd0, 0);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, 4'd15, 0);
        // Out-of-range write must not alias onto address 5.
        do_access(1'b1, 16'h0105, 16'hBEEF, 1'b1, 4'd1, 0);
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, 4'd0, 0);
        do_access(1'b0, 16'h0105, 16'h0000, 1'b1, 4'd0, 0);
        // Inputs disturbed and req dropped during WAIT.
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, 4'd4, 1);
        reset_mid_access();
        do_access(1'b0, 16'h0005, 16'h0000, 1'b1, 4'd0, 0);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            int r;
            logic [3:0] ov;
            logic oen;
            r   = $urandom_range(0, 9);
            ov  = 4'($urandom_range(0, 15));
            oen = 1'($urandom_range(0, 1));
            if (r < 4 || written_q.size() == 0) begin
                do_access(1'b1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)), oen, ov, 0);
            end else if (r < 6) begin
                do_access(1'b0, 16'(written_q[$urandom_range(0, written_q.size() - 1)]), 16'd0, oen, ov, 0);
            end else if (r < 8) begin
                do_access(1'($urandom_range(0, 1)), 16'($urandom_range(256, 65535)),
                          16'($urandom_range(0, 65535)), oen, ov, 0);
            end else begin
                do_access(1'b0, 16'(written_q[$urandom_range(0, written_q.size() - 1)]), 16'd0,
                          1'b1, 4'($urandom_range(2, 15)), 1);
            end
        end

        // Saturation: preload the read counter near its ceiling.
        @(negedge clock);
        force dut.rd_count = 16'hFFFD;
        #1;
        release dut.rd_count;
        m_rd = 65533;
        repeat (4) do_access(1'b0, 16'h0105, 16'h0000, 1'b1, 4'd0, 0);

        repeat (5) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
